stock_talon_ctrl: RTL and testbench

- Owns the stock and talon piles after the deal.
- Loads the 24-card stock produced by the dealing stage when that stage reports ready.
- Serves draw requests (stock to talon, face-up, draw-1 or draw-3), take requests (pop the talon top for a move elsewhere) and recycle (talon back to stock, face-down, when stock is empty).
- Sequential, one card moved per cycle. Exposes the flattened piles in the standard 7-bit card format to the game/display logic.

---
 rtl/stock_talon_ctrl.sv | 155 +++++++++++++++
 tb/tb_stock_talon_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stock_talon_ctrl.sv
// Stock/talon pile controller: loads the dealt stock, then serves
// draw, take and recycle requests moving one card per clock.
module stock_talon_ctrl #(
  parameter int DEPTH  = 24,
  parameter int CARD_W = 7,
  parameter int DRAW_N = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DEPTH*CARD_W-1:0] stock_in,
  input  logic                    draw_req,
  input  logic                    take_req,
  output logic [DEPTH*CARD_W-1:0] stock_pile,
  output logic [DEPTH*CARD_W-1:0] talon_pile,
  output logic [4:0]              stock_count,
  output logic [4:0]              talon_count,
  output logic [CARD_W-1:0]       talon_top,
  output logic                    busy,
  output logic                    op_done,
  output logic                    op_err,
  output logic [7:0]              pass_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAW, RECYCLE, TAKE, FINISH
  } state_t;

  typedef logic [CARD_W-1:0] card_t;

  localparam logic [4:0] DRAW_W = 5'(DRAW_N);

  state_t     state;
  state_t     state_n;
  card_t      stock [DEPTH];
  card_t      talon [DEPTH];
  logic [4:0] rem;
  logic       err;
  logic [4:0] s_top;
  logic [4:0] t_top;
  logic       s_any;
  logic       t_any;
  logic [4:0] draw_cnt;
  logic [4:0] load_cnt;
  logic       draw_bad;

  assign s_any    = stock_count != 5'd0;
  assign t_any    = talon_count != 5'd0;
  assign s_top    = stock_count - 5'd1;
  assign t_top    = talon_count - 5'd1;
  assign draw_cnt = (stock_count < DRAW_W) ? stock_count : DRAW_W;
  assign draw_bad = !load && !take_req && draw_req && !s_any && !t_any;

  assign talon_top = t_any ? talon[t_top] : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stock_pile[g*CARD_W +: CARD_W] = stock[g];
    assign talon_pile[g*CARD_W +: CARD_W] = talon[g];
  end

  always_comb begin
    load_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stock_in[i*CARD_W +: CARD_W] != '0)
        load_cnt = load_cnt + 5'd1;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b1;
    op_done = 1'b0;
    op_err  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (load)          state_n = LOAD;
        else if (take_req) state_n = TAKE;
        else if (draw_req) state_n = (!s_any && t_any) ? RECYCLE : DRAW;
      end
      LOAD:    state_n = FINISH;
      TAKE:    state_n = FINISH;
      DRAW:    if (rem <= 5'd1) state_n = FINISH;
      RECYCLE: if (talon_count <= 5'd1) state_n = FINISH;
      FINISH: begin
        op_done = 1'b1;
        op_err  = err;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // rem == 0 in DRAW marks a draw with both piles empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stock_count <= '0;
      talon_count <= '0;
      pass_count  <= '0;
      rem         <= '0;
      err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stock[i] <= '0;
        talon[i] <= '0;
      end
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          rem <= draw_cnt;
          err <= draw_bad;
        end
        LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            stock[i] <= stock_in[i*CARD_W +: CARD_W];
            talon[i] <= '0;
          end
          stock_count <= load_cnt;
          talon_count <= '0;
          pass_count  <= '0;
        end
        DRAW: begin
          if (rem != 5'd0) begin
            talon[talon_count] <= {stock[s_top][CARD_W-1:1], 1'b1};
            stock[s_top]       <= '0;
            stock_count        <= s_top;
            talon_count        <= talon_count + 5'd1;
            rem                <= rem - 5'd1;
          end
        end
        RECYCLE: begin
          if (t_any) begin
            stock[stock_count] <= {talon[t_top][CARD_W-1:1], 1'b0};
            talon[t_top]       <= '0;
            stock_count        <= stock_count + 5'd1;
            talon_count        <= t_top;
            if (talon_count == 5'd1 && pass_count != 8'hFF)
              pass_count <= pass_count + 8'd1;
          end
        end
        TAKE: begin
          if (t_any) begin
            talon[t_top] <= '0;
            talon_count  <= t_top;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stock_talon_ctrl.sv
// Scoreboard bench for stock_talon_ctrl: one DRAW_N=1 and one
// DRAW_N=3 instance driven through load/draw/take/recycle ops.
module tb_stock_talon_ctrl;

  localparam int D  = 24;
  localparam int W  = 7;
  localparam int PW = D * W;

  typedef struct {
    logic [4:0]    sc;
    logic [4:0]    tc;
    logic [6:0]    top;
    logic          e;
    logic [7:0]    pass;
    logic [PW-1:0] s;
    logic [PW-1:0] t;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] stock_in = '0;
  logic          load     [2];
  logic          draw_req [2];
  logic          take_req [2];
  logic [PW-1:0] sp   [2];
  logic [PW-1:0] tp   [2];
  logic [4:0]    sc   [2];
  logic [4:0]    tc   [2];
  logic [6:0]    top  [2];
  logic          busy [2];
  logic          done [2];
  logic          oerr [2];
  logic [7:0]    pc   [2];

  logic [6:0] ms [2][D];
  logic [6:0] mt [2][D];
  int         msc   [2];
  int         mtc   [2];
  int         mpass [2];
  exp_t       q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stock_talon_ctrl #(.DRAW_N(1)) u1 (
    .clk(clk), .rst(rst), .load(load[0]), .stock_in(stock_in),
    .draw_req(draw_req[0]), .take_req(take_req[0]),
    .stock_pile(sp[0]), .talon_pile(tp[0]),
    .stock_count(sc[0]), .talon_count(tc[0]), .talon_top(top[0]),
    .busy(busy[0]), .op_done(done[0]), .op_err(oerr[0]),
    .pass_count(pc[0])
  );

  stock_talon_ctrl #(.DRAW_N(3)) u3 (
    .clk(clk), .rst(rst), .load(load[1]), .stock_in(stock_in),
    .draw_req(draw_req[1]), .take_req(take_req[1]),
    .stock_pile(sp[1]), .talon_pile(tp[1]),
    .stock_count(sc[1]), .talon_count(tc[1]), .talon_top(top[1]),
    .busy(busy[1]), .op_done(done[1]), .op_err(oerr[1]),
    .pass_count(pc[1])
  );

  task automatic chk(input string tag,
                     input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] card(input int i, input bit f);
    return {4'(i / 2 + 1), 2'(i % 4), f};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < D; i++) begin
        ms[d][i] = '0;
        mt[d][i] = '0;
      end
      msc[d] = 0;
      mtc[d] = 0;
      mpass[d] = 0;
    end
  endtask

  // kind: 0 load, 1 take, 2 draw, 3 load+draw together
  task automatic model_op(input int d, input int kind,
                          output int cyc, output bit e);
    int n;
    int m;
    e = 1'b0;
    cyc = 2;
    n = (d == 1) ? 3 : 1;
    if (kind == 0 || kind == 3) begin
      msc[d] = 0;
      for (int i = 0; i < D; i++) begin
        ms[d][i] = stock_in[i*W +: W];
        mt[d][i] = '0;
        if (ms[d][i] != '0) msc[d]++;
      end
      mtc[d] = 0;
      mpass[d] = 0;
    end else if (kind == 1) begin
      if (mtc[d] > 0) begin
        mtc[d]--;
        mt[d][mtc[d]] = '0;
      end else e = 1'b1;
    end else if (msc[d] > 0) begin
      m = (msc[d] < n) ? msc[d] : n;
      for (int k = 0; k < m; k++) begin
        mt[d][mtc[d]] = ms[d][msc[d]-1] | 7'd1;
        ms[d][msc[d]-1] = '0;
        msc[d]--;
        mtc[d]++;
      end
      cyc = m + 1;
    end else if (mtc[d] > 0) begin
      m = mtc[d];
      for (int k = 0; k < m; k++) begin
        mtc[d]--;
        ms[d][msc[d]] = mt[d][mtc[d]] & 7'h7E;
        mt[d][mtc[d]] = '0;
        msc[d]++;
      end
      if (mpass[d] < 255) mpass[d]++;
      cyc = m + 1;
    end else e = 1'b1;
  endtask

  task automatic push_exp(input int d, input int cyc, input bit e);
    exp_t x;
    x.sc   = 5'(msc[d]);
    x.tc   = 5'(mtc[d]);
    x.top  = (mtc[d] > 0) ? mt[d][mtc[d]-1] : 7'd0;
    x.e    = e;
    x.pass = 8'(mpass[d]);
    x.cyc  = cyc;
    for (int i = 0; i < D; i++) begin
      x.s[i*W +: W] = ms[d][i];
      x.t[i*W +: W] = mt[d][i];
    end
    q.push_back(x);
  endtask

  task automatic run_op(input int d, input int kind);
    int   cyc;
    int   n;
    bit   e;
    bit   seen;
    exp_t x;
    @(negedge clk);
    model_op(d, kind, cyc, e);
    push_exp(d, cyc, e);
    load[d]     = (kind == 0 || kind == 3);
    take_req[d] = (kind == 1);
    draw_req[d] = (kind == 2 || kind == 3);
    @(posedge clk);
    #1;
    load[d] = 1'b0;
    take_req[d] = 1'b0;
    draw_req[d] = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (busy[d]) n++;
      if (done[d]) seen = 1'b1;
    end
    chk("op_done_seen", PW'(seen), PW'(1));
    x = q.pop_front();
    if (seen) begin
      chk("op_err", PW'(oerr[d]), PW'(x.e));
      chk("stock_count", PW'(sc[d]), PW'(x.sc));
      chk("talon_count", PW'(tc[d]), PW'(x.tc));
      chk("talon_top", PW'(top[d]), PW'(x.top));
      chk("pass_count", PW'(pc[d]), PW'(x.pass));
      chk("stock_pile", sp[d], x.s);
      chk("talon_pile", tp[d], x.t);
      chk("busy_cycles", PW'(n), PW'(x.cyc));
    end
    @(negedge clk);
    chk("idle_busy", PW'(busy[d]), PW'(0));
    chk("idle_done", PW'(done[d]), PW'(0));
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_sc"}, PW'(sc[d]), PW'(0));
    chk({tag, "_tc"}, PW'(tc[d]), PW'(0));
    chk({tag, "_top"}, PW'(top[d]), PW'(0));
    chk({tag, "_busy"}, PW'(busy[d]), PW'(0));
    chk({tag, "_done"}, PW'(done[d]), PW'(0));
    chk({tag, "_err"}, PW'(oerr[d]), PW'(0));
    chk({tag, "_pass"}, PW'(pc[d]), PW'(0));
    chk({tag, "_sp"}, sp[d], PW'(0));
    chk({tag, "_tp"}, tp[d], PW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      load[d] = 1'b0;
      draw_req[d] = 1'b0;
      take_req[d] = 1'b0;
    end
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst = 1'b1;

    for (int i = 0; i < D; i++) stock_in[i*W +: W] = card(i, 1'b1);
    run_op(0, 0);
    chk("load_sc_24", PW'(sc[0]), PW'(24));
    run_op(0, 2);
    chk("draw1_top", PW'(top[0]), PW'(card(23, 1'b1)));

    stock_in = '0;
    for (int i = 0; i < 5; i++) stock_in[i*W +: W] = card(i, 1'b1);
    run_op(1, 0);
    run_op(1, 2);
    run_op(1, 1);
    run_op(1, 1);
    run_op(1, 2);
    chk("draw3_top", PW'(top[1]), PW'(card(0, 1'b1)));
    run_op(1, 2);
    chk("recycle_s0", PW'(sp[1][6:0]), PW'(card(0, 1'b0)));
    chk("recycle_s2", PW'(sp[1][20:14]), PW'(card(4, 1'b0)));
    run_op(1, 1);
    stock_in = '0;
    run_op(1, 0);
    run_op(1, 2);

    for (int k = 0; k < 23; k++) run_op(0, 2);
    @(negedge clk);
    draw_req[0] = 1'b1;
    @(posedge clk);
    #1 draw_req[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_recycle_busy", PW'(busy[0]), PW'(1));
    rst = 1'b0;
    #1;
    chk_zero(0, "midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < D; i++) stock_in[i*W +: W] = card(i, 1'b1);
    run_op(0, 3);
    run_op(0, 2);
    run_op(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
